// File: rtl/rf_scoreboard.sv
// rf_scoreboard: parametrised two-read / one-write register file for the
// 16-bit CPU datapath. It adds same-cycle write-to-read forwarding, an
// optional hard-wired zero register, and a per-register pending scoreboard
// so decode can detect RAW hazards (reserve) and writeback can retire them.
module rf_scoreboard #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter bit ZERO_R0  = 1'b0,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_reg_x,
    input  logic [ADDR_W-1:0] i_reg_y,
    output logic [DATA_W-1:0] o_data_1,
    output logic [DATA_W-1:0] o_data_2,
    output logic              o_busy_1,
    output logic              o_busy_2,
    input  logic              i_RF_write,
    input  logic [ADDR_W-1:0] i_reg_w,
    input  logic [DATA_W-1:0] i_data_w,
    input  logic              i_reserve,
    input  logic [ADDR_W-1:0] i_reg_r,
    output logic              o_reserve_ok,
    output logic [ADDR_W:0]   o_pending_cnt
);

    logic [DATA_W-1:0]   mem_r [NUM_REGS];
    logic [NUM_REGS-1:0] pend_r;
    logic [ADDR_W:0]     cnt_r;

    logic                wr_en_s;
    logic                zero_x_s;
    logic                zero_y_s;
    logic                fwd_x_s;
    logic                fwd_y_s;
    logic [DATA_W-1:0]   data_1_s;
    logic [DATA_W-1:0]   data_2_s;
    logic                busy_1_s;
    logic                busy_2_s;
    logic                rsv_zero_s;
    logic                wr_hit_r_s;
    logic                reserve_ok_s;
    logic                rsv_set_s;
    logic                cnt_inc_s;
    logic                cnt_dec_s;
    logic [NUM_REGS-1:0] pend_next_s;
    logic [ADDR_W:0]     cnt_next_s;

    // Decode the address qualifiers: effective write, zero-register hits and forwarding hits.
    always_comb begin
        wr_en_s    = i_RF_write && !(ZERO_R0 && (i_reg_w == {ADDR_W{1'b0}}));
        zero_x_s   = ZERO_R0 && (i_reg_x == {ADDR_W{1'b0}});
        zero_y_s   = ZERO_R0 && (i_reg_y == {ADDR_W{1'b0}});
        fwd_x_s    = BYPASS && i_RF_write && (i_reg_w == i_reg_x);
        fwd_y_s    = BYPASS && i_RF_write && (i_reg_w == i_reg_y);
        rsv_zero_s = ZERO_R0 && (i_reg_r == {ADDR_W{1'b0}});
        wr_hit_r_s = wr_en_s && (i_reg_w == i_reg_r);
    end

    // Read port 1: zero register wins, then forwarded write data, then storage.
    always_comb begin
        data_1_s = mem_r[i_reg_x];
        busy_1_s = pend_r[i_reg_x];
        if (zero_x_s) begin
            data_1_s = {DATA_W{1'b0}};
            busy_1_s = 1'b0;
        end else if (fwd_x_s) begin
            // Forwarded data is final, so the reservation no longer blocks.
            data_1_s = i_data_w;
            busy_1_s = 1'b0;
        end else begin
            data_1_s = mem_r[i_reg_x];
            busy_1_s = pend_r[i_reg_x];
        end
    end

    // Read port 2: same priority as port 1.
    always_comb begin
        data_2_s = mem_r[i_reg_y];
        busy_2_s = pend_r[i_reg_y];
        if (zero_y_s) begin
            data_2_s = {DATA_W{1'b0}};
            busy_2_s = 1'b0;
        end else if (fwd_y_s) begin
            data_2_s = i_data_w;
            busy_2_s = 1'b0;
        end else begin
            data_2_s = mem_r[i_reg_y];
            busy_2_s = pend_r[i_reg_y];
        end
    end

    // Reserve arbitration and counter deltas; a write to the reserved register retires it first.
    always_comb begin
        reserve_ok_s = i_reserve && (rsv_zero_s || !pend_r[i_reg_r] || wr_hit_r_s);
        rsv_set_s    = reserve_ok_s && !rsv_zero_s;
        cnt_dec_s    = wr_en_s && pend_r[i_reg_w];
        // Re-reserving a register that the same write clears counts as +1 against its -1.
        cnt_inc_s    = rsv_set_s && (!pend_r[i_reg_r] || wr_hit_r_s);
        cnt_next_s   = cnt_r + {{ADDR_W{1'b0}}, cnt_inc_s} - {{ADDR_W{1'b0}}, cnt_dec_s};
    end

    // Next pending vector: clear on retiring write, then set on accepted reserve.
    always_comb begin
        pend_next_s = pend_r;
        if (wr_en_s) begin
            pend_next_s[i_reg_w] = 1'b0;
        end else begin
            pend_next_s = pend_r;
        end
        if (rsv_set_s) begin
            pend_next_s[i_reg_r] = 1'b1;
        end else begin
            pend_next_s[i_reg_r] = pend_next_s[i_reg_r];
        end
    end

    // State update: storage, pending bits and counter; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            pend_r <= {NUM_REGS{1'b0}};
            cnt_r  <= {(ADDR_W + 1){1'b0}};
        end else begin
            if (wr_en_s) begin
                mem_r[i_reg_w] <= i_data_w;
            end
            pend_r <= pend_next_s;
            cnt_r  <= cnt_next_s;
        end
    end

    assign o_data_1      = data_1_s;
    assign o_data_2      = data_2_s;
    assign o_busy_1      = busy_1_s;
    assign o_busy_2      = busy_2_s;
    assign o_reserve_ok  = reserve_ok_s;
    assign o_pending_cnt = cnt_r;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Testbench for rf_scoreboard: two instances share one stimulus stream,
// instance 0 with forwarding and no zero register, instance 1 with a
// hard-wired zero register and no forwarding. A behavioural model per
// instance (plain arrays, popcount for the pending count) predicts every
// output each cycle.
module tb_rf_scoreboard;

    logic        clk;
    logic        rst;
    logic [2:0]  x;
    logic [2:0]  y;
    logic        we;
    logic [2:0]  w;
    logic [15:0] dw;
    logic        rsv;
    logic [2:0]  r;

    logic [15:0] d1  [2];
    logic [15:0] d2  [2];
    logic        b1  [2];
    logic        b2  [2];
    logic        ok  [2];
    logic [3:0]  cnt [2];

    int total = 0;
    int bad   = 0;

    logic [15:0] mmem  [2][8];
    bit          mpend [2][8];

    rf_scoreboard #(.DATA_W(16), .NUM_REGS(8), .ZERO_R0(1'b0), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst),
        .i_reg_x(x), .i_reg_y(y),
        .o_data_1(d1[0]), .o_data_2(d2[0]),
        .o_busy_1(b1[0]), .o_busy_2(b2[0]),
        .i_RF_write(we), .i_reg_w(w), .i_data_w(dw),
        .i_reserve(rsv), .i_reg_r(r),
        .o_reserve_ok(ok[0]), .o_pending_cnt(cnt[0])
    );

    rf_scoreboard #(.DATA_W(16), .NUM_REGS(8), .ZERO_R0(1'b1), .BYPASS(1'b0)) dut_z (
        .clk(clk), .rst(rst),
        .i_reg_x(x), .i_reg_y(y),
        .o_data_1(d1[1]), .o_data_2(d2[1]),
        .o_busy_1(b1[1]), .o_busy_2(b2[1]),
        .i_RF_write(we), .i_reg_w(w), .i_data_w(dw),
        .i_reserve(rsv), .i_reg_r(r),
        .o_reserve_ok(ok[1]), .o_pending_cnt(cnt[1])
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit zr(int c);
        return c == 1;
    endfunction

    function automatic bit bp(int c);
        return c == 0;
    endfunction

    function automatic logic [15:0] m_read(int c, logic [2:0] a);
        if (zr(c) && a == 3'd0) return 16'h0000;
        if (bp(c) && we && w == a) return dw;
        return mmem[c][a];
    endfunction

    function automatic bit m_busy(int c, logic [2:0] a);
        if (zr(c) && a == 3'd0) return 1'b0;
        if (bp(c) && we && w == a) return 1'b0;
        return mpend[c][a];
    endfunction

    function automatic bit m_ok(int c);
        if (!rsv) return 1'b0;
        if (zr(c) && r == 3'd0) return 1'b1;
        return !mpend[c][r] || (we && w == r);
    endfunction

    function automatic int m_cnt(int c);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(mpend[c][i]);
        return n;
    endfunction

    function automatic void m_update(int c);
        bit acc = m_ok(c);
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                mmem[c][i]  = 16'h0000;
                mpend[c][i] = 1'b0;
            end
        end else begin
            if (we && !(zr(c) && w == 3'd0)) begin
                mmem[c][w]  = dw;
                mpend[c][w] = 1'b0;
            end
            if (acc && !(zr(c) && r == 3'd0)) mpend[c][r] = 1'b1;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check all outputs mid-cycle, then advance the model on the edge.
    task automatic cycle();
        @(negedge clk);
        for (int c = 0; c < 2; c++) begin
            chk($sformatf("data_1 c%0d x=%0d", c, x), 32'(d1[c]), 32'(m_read(c, x)));
            chk($sformatf("data_2 c%0d y=%0d", c, y), 32'(d2[c]), 32'(m_read(c, y)));
            chk($sformatf("busy_1 c%0d x=%0d", c, x), 32'(b1[c]), 32'(m_busy(c, x)));
            chk($sformatf("busy_2 c%0d y=%0d", c, y), 32'(b2[c]), 32'(m_busy(c, y)));
            chk($sformatf("reserve_ok c%0d r=%0d", c, r), 32'(ok[c]), 32'(m_ok(c)));
            chk($sformatf("pending_cnt c%0d", c), 32'(cnt[c]), 32'(m_cnt(c)));
        end
        @(posedge clk);
        for (int c = 0; c < 2; c++) m_update(c);
        #1;
    endtask

    initial begin
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 8; i++) begin
                mmem[c][i]  = 16'h0000;
                mpend[c][i] = 1'b0;
            end
        rst = 1'b1; x = 3'd0; y = 3'd0; we = 1'b0; w = 3'd0; dw = 16'h0000;
        rsv = 1'b0; r = 3'd0;
        cycle();
        rst = 1'b0;

        // Reset sweep of both read ports.
        for (int i = 0; i < 8; i++) begin
            x = 3'(i); y = 3'(7 - i);
            cycle();
        end

        // Write / readback, same-cycle read during the write.
        we = 1'b1; w = 3'd3; dw = 16'hA5A5; x = 3'd3; y = 3'd3;
        cycle();
        we = 1'b0;
        cycle();

        // Scoreboard on r5: accept, reject, retire with forwarding.
        rsv = 1'b1; r = 3'd5; x = 3'd5; y = 3'd3;
        cycle();
        cycle();
        rsv = 1'b0; we = 1'b1; w = 3'd5; dw = 16'h1234;
        cycle();
        we = 1'b0;
        cycle();

        // Simultaneous write and re-reserve of a pending r2.
        rsv = 1'b1; r = 3'd2; x = 3'd2; y = 3'd5;
        cycle();
        we = 1'b1; w = 3'd2; dw = 16'hBEEF;
        cycle();
        rsv = 1'b0; we = 1'b0;
        cycle();

        // Register 0 write and reserve.
        we = 1'b1; w = 3'd0; dw = 16'hFFFF; rsv = 1'b1; r = 3'd0; x = 3'd0; y = 3'd0;
        cycle();
        we = 1'b0;
        cycle();
        rsv = 1'b0;
        cycle();

        // Reset in the middle of activity, coincident with a write to r7.
        rsv = 1'b1; r = 3'd1; x = 3'd1; y = 3'd6;
        cycle();
        r = 3'd6;
        cycle();
        rsv = 1'b0; we = 1'b1; w = 3'd4; dw = 16'h00FF; x = 3'd4;
        cycle();
        w = 3'd7; dw = 16'h7777; rst = 1'b1;
        cycle();
        rst = 1'b0; we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            x = 3'(i); y = 3'(7 - i);
            cycle();
        end

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            x   = 3'($urandom_range(0, 7));
            y   = 3'($urandom_range(0, 7));
            w   = 3'($urandom_range(0, 7));
            r   = 3'($urandom_range(0, 7));
            dw  = 16'($urandom);
            we  = ($urandom_range(0, 2) == 0);
            rsv = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 9) == 0) y = x;
            if ($urandom_range(0, 5) == 0) r = w;
            rst = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Parametrised multi-ported register file with an integrated per-register scoreboard, for the 16-bit CPU datapath. It widens the existing 8x16 two-read/one-write register file to configurable width and depth. It adds same-cycle write-to-read bypass, an optional hard-wired zero register, and pending-write tracking so the decode stage can detect RAW hazards and stall. It sits between decode (reads/reserves) and writeback (writes/retires).

## Interface
Parameters:
- DATA_W, 16, register width in bits
- NUM_REGS, 8, number of registers (power of two, >=2)
- ADDR_W, $clog2(NUM_REGS), register address width
- ZERO_R0, 0, 1 = register 0 reads as zero; writes and reserves to it are ignored
- BYPASS, 1, 1 = a write in progress is forwarded to matching read ports in the same cycle

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- i_reg_x  in  ADDR_W  read port 1 address
- i_reg_y  in  ADDR_W  read port 2 address
- o_data_1  out  DATA_W  read port 1 data (combinational)
- o_data_2  out  DATA_W  read port 2 data (combinational)
- o_busy_1  out  1  register at i_reg_x has an outstanding reservation
- o_busy_2  out  1  register at i_reg_y has an outstanding reservation
- i_RF_write  in  1  write enable (writeback)
- i_reg_w  in  ADDR_W  write address
- i_data_w  in  DATA_W  write data
- i_reserve  in  1  reserve-request strobe (decode marks destination pending)
- i_reg_r  in  ADDR_W  reserve address
- o_reserve_ok  out  1  reservation accepted this cycle (combinational)
- o_pending_cnt  out  ADDR_W+1  number of registers currently pending

## Operation
- Storage: NUM_REGS x DATA_W array plus pending[NUM_REGS] bit vector and a pending counter.
- Read, per port: if ZERO_R0 and addr==0, return 0. Else, if BYPASS and i_RF_write and i_reg_w==addr, return i_data_w. Else return the stored value.
- Busy, per port: pending[addr], forced to 0 when ZERO_R0 and addr==0. Also forced to 0 when BYPASS and i_RF_write and i_reg_w==addr, because the data is being forwarded.
- Write: on an edge with i_RF_write, store i_data_w at i_reg_w and clear pending[i_reg_w]. Dropped entirely if ZERO_R0 and i_reg_w==0. A write to a non-pending register is legal; pending is unchanged.
- Reserve:
  - o_reserve_ok = i_reserve and (pending[i_reg_r]==0, or a write to i_reg_r occurs this cycle).
  - When ZERO_R0 and i_reg_r==0: o_reserve_ok = i_reserve and no state change.
  - An accepted reserve sets pending[i_reg_r] on the edge. A rejected reserve changes nothing; decode must hold and retry.
- Same register written and reserved in one cycle: the write retires the old reservation, the new reservation is accepted, and pending stays 1. Counter is unchanged (+1 and -1).
- Counter: +1 per accepted reserve that newly sets a bit, -1 per write that clears a set bit. Never exceeds NUM_REGS and never underflows.
- Reset (rst=1 at edge): all registers 0, pending all 0, o_pending_cnt=0. Overrides any write or reserve in the same cycle.

## Timing
- Read data and busy: combinational from address, stored state and current write inputs; zero-cycle latency.
- Without BYPASS, a write becomes visible on reads the cycle after the edge.
- o_reserve_ok is combinational; pending and counter update on the same edge.
- Outputs after reset: o_data_1/2 = 0, o_busy_1/2 = 0, o_pending_cnt = 0, and o_reserve_ok = i_reserve.
- Two read ports may address the same register; both return identical data and busy.

## Test plan
- Reset then read all: assert rst 1 cycle, then sweep i_reg_x/i_reg_y over 0..7 -> all data 0, busy 0, cnt 0.
- Write/readback: write 16'hA5A5 to r3, next cycle read x=3,y=3 -> both 16'hA5A5; with BYPASS=1, the same-cycle read during the write also returns 16'hA5A5.
- Scoreboard: reserve r5 -> ok=1, cnt=1, busy_1=1 at x=5. Reserve r5 again -> ok=0, cnt=1. Write r5=16'h1234 -> busy_1=0 in the same cycle (bypass), cnt=0 after the edge.
- Simultaneous write+reserve of r2 while pending -> ok=1, pending[2] stays 1, cnt unchanged, r2 holds the new data.
- ZERO_R0=1: write 16'hFFFF to r0, reserve r0 -> read r0=0, busy 0, ok=1, cnt 0.
- Reset mid-operation: reserve r1/r6 and write r4=16'h00FF, then rst for 1 cycle coincident with a write to r7 -> all data 0, cnt 0, r7 = 0.
